// File: rtl/bram_byte_mem_ctrl_if.sv
// Bus bundle between the core data port, the byte controller and an 8-bit block RAM.
// The slave view belongs to the controller; the master view is the core plus RAM side.
interface bram_byte_mem_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/bram_byte_mem_ctrl.sv
// rv32i load/store to byte-serial block RAM controller, little-endian, one request in flight.
// All outputs are registered from the next-state decode so each one lines up with its state.
module bram_byte_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rst_n,
    bram_byte_mem_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    logic                    drain_q, drain_d;

    logic                    we_q, uns_q, err_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;

    logic [31:0]             lanes_q, lanes_d;
    logic [1:0]              cap_q;
    logic [RD_LATENCY-1:0]   rd_pipe_q;

    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]              mem_din_q, mem_din_d;

    logic                    accept_c;
    logic                    req_err_c;
    logic                    cap_fire_c;
    logic                    cur_we, cur_uns, cur_err;
    logic [1:0]              cur_size, last_beat_c;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [31:0]             cur_wdata;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;

    // Sign/zero extension from the top loaded byte.
    function automatic logic [31:0] load_ext(input logic [31:0] b, input logic [1:0] sz,
                                             input logic uns);
        case (sz)
            2'd0:    load_ext = {{24{~uns & b[7]}}, b[7:0]};
            2'd1:    load_ext = {{16{~uns & b[15]}}, b[15:0]};
            default: load_ext = b;
        endcase
    endfunction

    assign accept_c   = bus.req_valid & req_ready_q;
    assign req_err_c  = (bus.req_size == 2'd3)
                      | ((bus.req_size == 2'd1) & bus.req_addr[0])
                      | ((bus.req_size == 2'd2) & (bus.req_addr[1:0] != 2'b00));
    assign cap_fire_c = rd_pipe_q[RD_LATENCY-1];

    // On the accept edge the request is not latched yet, so decode straight from the inputs.
    assign cur_we    = accept_c ? bus.req_we       : we_q;
    assign cur_uns   = accept_c ? bus.req_unsigned : uns_q;
    assign cur_err   = accept_c ? req_err_c        : err_q;
    assign cur_size  = accept_c ? bus.req_size     : size_q;
    assign cur_addr  = accept_c ? bus.req_addr     : addr_q;
    assign cur_wdata = accept_c ? bus.req_wdata    : wdata_q;

    always_comb begin
        case (cur_size)
            2'd0:    last_beat_c = 2'd0;
            2'd1:    last_beat_c = 2'd1;
            default: last_beat_c = 2'd3;
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        lanes_d     = lanes_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_din_d   = '0;

        if (cap_fire_c) lanes_d[{cap_q, 3'b000} +: 8] = bus.mem_dout;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = req_err_c ? RESP : ISSUE;
                    beat_d  = 2'd0;
                end
            end
            ISSUE: begin
                if (beat_q == last_beat_c) begin
                    state_d = we_q ? RESP : DRAIN;
                    drain_d = 1'b0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            DRAIN: begin
                if (drain_q == 1'(RD_LATENCY - 1)) state_d = RESP;
                else                               drain_d = drain_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        if (state_d == ISSUE) begin
            mem_en_d   = 1'b1;
            mem_we_d   = cur_we;
            mem_addr_d = cur_addr + ADDR_WIDTH'(beat_d);
            mem_din_d  = cur_we ? cur_wdata[{beat_d, 3'b000} +: 8] : 8'h00;
        end
        if (state_d == RESP) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_err;
            rsp_rdata_d = (cur_err | cur_we) ? 32'h0 : load_ext(lanes_d, cur_size, cur_uns);
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            drain_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    // Request latch and read-capture tracking; the pipe marks which cycles carry read data.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lanes_q   <= '0;
            cap_q     <= '0;
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= RD_LATENCY'({rd_pipe_q, mem_en_q & ~mem_we_q});
            if (accept_c) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_err_c;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                lanes_q <= '0;
                cap_q   <= '0;
            end else if (cap_fire_c) begin
                lanes_q <= lanes_d;
                cap_q   <= cap_q + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_bram_byte_mem_ctrl.sv
// Bench for bram_byte_mem_ctrl: block RAM model, expectation queue, one task per scenario.
module tb_bram_byte_mem_ctrl;
    localparam int unsigned AW = 11;
    localparam int unsigned RL = 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        exp_t        e;
    } req_t;

    logic clka;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    bram_byte_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    bram_byte_mem_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    // Untouched RAM locations read back a fixed address-derived pattern.
    function automatic logic [7:0] pattern(input int unsigned a);
        return 8'((a * 7 + 3) & 32'hFF);
    endfunction

    logic [7:0]         ram [2048];
    bit   [2047:0]      ram_wr = '0;
    logic [7:0]         dout1 = 8'h00;
    logic [7:0]         dout2 = 8'h00;

    always @(posedge clka) begin
        cyc <= cyc + 1;
        if (bus.mem_en) begin
            en_cnt <= en_cnt + 1;
            dout1  <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : pattern(int'(bus.mem_addr));
            if (bus.mem_we) begin
                ram[bus.mem_addr]    <= bus.mem_din;
                ram_wr[bus.mem_addr] <= 1'b1;
            end
        end
        dout2 <= dout1;
    end
    assign bus.mem_dout = (RL == 1) ? dout1 : dout2;

    function automatic req_t mk(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [AW-1:0] addr,
                                input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata, input int lat);
        req_t r;
        r.name = name; r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        r.e.err = err; r.e.rdata = rdata; r.e.lat = lat;
        return r;
    endfunction

    task automatic drive(input req_t r);
        bus.req_we       = r.we;
        bus.req_size     = r.size;
        bus.req_unsigned = r.uns;
        bus.req_addr     = r.addr;
        bus.req_wdata    = r.wdata;
    endtask

    // Present a request until accepted, then scramble the inputs to prove they are latched.
    task automatic issue(input req_t r);
        @(negedge clka);
        drive(r);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && bus.req_ready !== 1'b1; i++) @(negedge clka);
        if (bus.req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_accept: req_ready=%0b, required 1 within 50 cycles", r.name, bus.req_ready);
        end
        acc_cyc = cyc;
        @(posedge clka);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = AW'($urandom);
        bus.req_wdata    = $urandom;
    endtask

    task automatic collect(output bit seen, output exp_t got);
        seen = 1'b0;
        got.err = 1'b0; got.rdata = '0; got.lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clka);
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                got.err = bus.rsp_err;
                got.rdata = bus.rsp_rdata;
                got.lat = cyc - acc_cyc;
                break;
            end
        end
    endtask

    task automatic xact(input req_t r, output bit seen, output exp_t got, output exp_t want);
        exp_q.push_back(r.e);
        issue(r);
        collect(seen, got);
        want = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        drive(mk("idle", 1'b0, 2'd0, 1'b0, '0, '0, 1'b0, '0, 0));
        #3;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b rsp_valid=%0b mem_en=%0b addr=%h, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.mem_en, bus.mem_addr);
        end
        repeat (2) @(negedge clka);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: req_ready=%0b, required 0", bus.req_ready);
        end
        @(posedge clka);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: req_ready=%0b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_word();
        req_t tbl[2];
        bit seen; exp_t got, want;
        tbl[0] = mk("sw_010", 1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, 1'b0, 32'h0, 5);
        tbl[1] = mk("lw_010", 1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4 + RL + 1);
        foreach (tbl[i]) begin
            xact(tbl[i], seen, got, want);
            checks++;
            if (!seen || got.err !== want.err || got.rdata !== want.rdata || got.lat != want.lat) begin
                errors++;
                $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                         tbl[i].name, seen, got.err, got.rdata, got.lat, want.err, want.rdata, want.lat);
            end
        end
        checks++;
        if ({ram[19], ram[18], ram[17], ram[16]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_010_bytes: ram[13:10]=%02h%02h%02h%02h, required DEADBEEF",
                     ram[19], ram[18], ram[17], ram[16]);
        end
    endtask

    task automatic test_byte_half();
        req_t tbl[6];
        bit seen; exp_t got, want;
        tbl[0] = mk("sb_020",  1'b1, 2'd0, 1'b0, 11'h020, 32'h12345680, 1'b0, 32'h0, 2);
        tbl[1] = mk("lb_020",  1'b0, 2'd0, 1'b0, 11'h020, 32'h0, 1'b0, 32'hFFFFFF80, 1 + RL + 1);
        tbl[2] = mk("lbu_020", 1'b0, 2'd0, 1'b1, 11'h020, 32'h0, 1'b0, 32'h00000080, 1 + RL + 1);
        tbl[3] = mk("sh_022",  1'b1, 2'd1, 1'b0, 11'h022, 32'hABCD8001, 1'b0, 32'h0, 3);
        tbl[4] = mk("lh_022",  1'b0, 2'd1, 1'b0, 11'h022, 32'h0, 1'b0, 32'hFFFF8001, 2 + RL + 1);
        tbl[5] = mk("lhu_022", 1'b0, 2'd1, 1'b1, 11'h022, 32'h0, 1'b0, 32'h00008001, 2 + RL + 1);
        foreach (tbl[i]) begin
            xact(tbl[i], seen, got, want);
            checks++;
            if (!seen || got.err !== want.err || got.rdata !== want.rdata || got.lat != want.lat) begin
                errors++;
                $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                         tbl[i].name, seen, got.err, got.rdata, got.lat, want.err, want.rdata, want.lat);
            end
        end
    endtask

    task automatic test_errors();
        req_t tbl[3];
        bit seen; exp_t got, want;
        int en_before;
        tbl[0] = mk("lw_011_mis", 1'b0, 2'd2, 1'b0, 11'h011, 32'h0, 1'b1, 32'h0, 1);
        tbl[1] = mk("sh_021_mis", 1'b1, 2'd1, 1'b0, 11'h021, 32'h5555AAAA, 1'b1, 32'h0, 1);
        tbl[2] = mk("size3_000",  1'b0, 2'd3, 1'b0, 11'h000, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        foreach (tbl[i]) begin
            en_before = en_cnt;
            xact(tbl[i], seen, got, want);
            checks++;
            if (!seen || got.err !== want.err || got.rdata !== want.rdata || got.lat != want.lat) begin
                errors++;
                $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                         tbl[i].name, seen, got.err, got.rdata, got.lat, want.err, want.rdata, want.lat);
            end
            @(negedge clka);
            checks++;
            if (en_cnt != en_before) begin
                errors++;
                $display("FAIL %s_no_access: mem_en cycles=%0d, required 0", tbl[i].name, en_cnt - en_before);
            end
        end
    endtask

    task automatic test_top();
        req_t tbl[2];
        bit seen; exp_t got, want;
        tbl[0] = mk("sw_7fc", 1'b1, 2'd2, 1'b0, 11'h7FC, 32'h11223344, 1'b0, 32'h0, 5);
        tbl[1] = mk("lw_7fc", 1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0, 32'h11223344, 4 + RL + 1);
        foreach (tbl[i]) begin
            xact(tbl[i], seen, got, want);
            checks++;
            if (!seen || got.err !== want.err || got.rdata !== want.rdata || got.lat != want.lat) begin
                errors++;
                $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                         tbl[i].name, seen, got.err, got.rdata, got.lat, want.err, want.rdata, want.lat);
            end
        end
        checks++;
        if ({ram[2047], ram[2046], ram[2045], ram[2044]} !== 32'h11223344 || ram_wr[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL sw_7fc_nowrap: top=%02h%02h%02h%02h low_written=%b, required 11223344 and 0000",
                     ram[2047], ram[2046], ram[2045], ram[2044], ram_wr[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        req_t sb, lb;
        bit seen1, seen2, acc2_seen;
        exp_t got1, got2, want;
        int acc1, acc2, rsp1_cyc;
        sb = mk("b2b_sb_005", 1'b1, 2'd0, 1'b0, 11'h005, 32'h000000AA, 1'b0, 32'h0, 2);
        lb = mk("b2b_lb_005", 1'b0, 2'd0, 1'b0, 11'h005, 32'h0, 1'b0, 32'hFFFFFFAA, 1 + RL + 1);
        seen1 = 1'b0; acc2_seen = 1'b0; acc2 = -1; rsp1_cyc = -100;
        got1.err = 1'b0; got1.rdata = '0; got1.lat = -1;
        exp_q.push_back(sb.e);
        exp_q.push_back(lb.e);
        @(negedge clka);
        drive(sb);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && bus.req_ready !== 1'b1; i++) @(negedge clka);
        acc1 = cyc;
        @(posedge clka);
        #1;
        drive(lb);
        for (int i = 0; i < 40 && !acc2_seen; i++) begin
            @(negedge clka);
            if (bus.rsp_valid === 1'b1 && !seen1) begin
                seen1 = 1'b1;
                got1.err = bus.rsp_err; got1.rdata = bus.rsp_rdata; got1.lat = cyc - acc1;
                rsp1_cyc = cyc;
            end
            if (bus.req_ready === 1'b1) begin
                acc2 = cyc;
                acc2_seen = 1'b1;
                @(posedge clka);
                #1;
                bus.req_valid = 1'b0;
            end
        end
        want = exp_q.pop_front();
        checks++;
        if (!seen1 || got1.err !== want.err || got1.rdata !== want.rdata || got1.lat != want.lat) begin
            errors++;
            $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                     sb.name, seen1, got1.err, got1.rdata, got1.lat, want.err, want.rdata, want.lat);
        end
        checks++;
        if (!acc2_seen || acc2 - rsp1_cyc != 1) begin
            errors++;
            $display("FAIL b2b_second_accept: cycles after rsp=%0d, required 1", acc2 - rsp1_cyc);
        end
        acc_cyc = acc2;
        collect(seen2, got2);
        want = exp_q.pop_front();
        checks++;
        if (!seen2 || got2.err !== want.err || got2.rdata !== want.rdata || got2.lat != want.lat) begin
            errors++;
            $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                     lb.name, seen2, got2.err, got2.rdata, got2.lat, want.err, want.rdata, want.lat);
        end
    endtask

    task automatic test_reset_abort();
        req_t sw, lw;
        bit seen, rsp_during;
        exp_t got, want;
        sw = mk("abort_sw_040", 1'b1, 2'd2, 1'b0, 11'h040, 32'h11223344, 1'b0, 32'h0, 0);
        lw = mk("lw_040_after", 1'b0, 2'd2, 1'b0, 11'h040, 32'h0, 1'b0,
                {pattern(32'h43), pattern(32'h42), 8'h33, 8'h44}, 4 + RL + 1);
        issue(sw);
        repeat (3) @(negedge clka);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 11'h042 || bus.mem_din !== 8'h22) begin
            errors++;
            $display("FAIL abort_beat2: en=%0b we=%0b addr=%h din=%h, required 1 1 042 22",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_din} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: ready=%0b mem_en=%0b addr=%h din=%h, required all 0",
                     bus.req_ready, bus.mem_en, bus.mem_addr, bus.mem_din);
        end
        rsp_during = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            if (bus.rsp_valid !== 1'b0) rsp_during = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            if (bus.rsp_valid !== 1'b0) rsp_during = 1'b1;
        end
        checks++;
        if (rsp_during) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid seen=%0b, required 0", rsp_during);
        end
        xact(lw, seen, got, want);
        checks++;
        if (!seen || got.err !== want.err || got.rdata !== want.rdata || got.lat != want.lat) begin
            errors++;
            $display("FAIL %s: seen=%0b err=%0b rdata=%08h lat=%0d, required err=%0b rdata=%08h lat=%0d",
                     lw.name, seen, got.err, got.rdata, got.lat, want.err, want.rdata, want.lat);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_top();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
